// File: rtl/ysyx_exu_lsu_arb_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_exu_lsu_arb_pkg
// Shared definitions for the EXU load/store arbiter:
//   - lsu_arb_state_e : 2-bit arbiter FSM state encoding
//   - ALU_W           : width of the alu-op field forwarded to memory
// The tag width depends on the reservation-station size and is derived
// locally in the arbiter.
// ----------------------------------------------------------------------------
package ysyx_exu_lsu_arb_pkg;

    localparam int ALU_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DRAIN = 2'd3
    } lsu_arb_state_e;

endpackage

// File: rtl/ysyx_exu_lsu_arb_starve.sv
// ----------------------------------------------------------------------------
// ysyx_exu_lsu_arb_starve
// Load-starvation counter. Counts store grants made while a load is waiting
// and raises o_hit once STARVE_LIMIT such grants have happened in a row, so
// the arbiter lets the waiting load through.
// Only instantiated when YSYX_LSU_ARB_STARVE_EN is defined.
//
// Ports:
//   clock       in  clock
//   reset       in  synchronous active-high reset, clears the count
//   i_idle      in  arbiter is in IDLE this cycle
//   i_ld_valid  in  a load request is pending
//   i_st_grant  in  store handshake this cycle
//   i_ld_grant  in  load handshake this cycle
//   o_hit       out count has reached STARVE_LIMIT
// ----------------------------------------------------------------------------
module ysyx_exu_lsu_arb_starve #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_idle,
    input  logic i_ld_valid,
    input  logic i_st_grant,
    input  logic i_ld_grant,
    output logic o_hit
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_ld_grant || (i_idle && !i_ld_valid)) begin
            // The waiting load was served or went away: starvation is over.
            r_cnt <= '0;
        end else if (i_st_grant && i_ld_valid && (r_cnt < LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_hit = (r_cnt >= LIMIT);

endmodule

// File: rtl/ysyx_exu_lsu_arb.sv
// ----------------------------------------------------------------------------
// ysyx_exu_lsu_arb
// Arbitrates a single memory port between speculative loads from the
// reservation station and committed stores. Stores have priority; with
// YSYX_LSU_ARB_STARVE_EN defined, a load that has waited through
// STARVE_LIMIT consecutive store grants wins the next arbitration.
// A pipeline flush cancels an outstanding load: the memory access is still
// drained to completion but its response is discarded. Stores are committed
// and are never cancelled.
//
// Parameters:
//   XLEN          data/address width
//   RS_SIZE       reservation-station entries (tag width = clog2(RS_SIZE))
//   STARVE_LIMIT  consecutive store grants tolerated while a load waits
//
// Ports:
//   clock, reset                         clock, synchronous active-high reset
//   flush_pipeline                       discard speculative loads
//   ld_req_valid/ready/addr/alu/tag      load request handshake
//   st_req_valid/ready/addr/data/alu     committed-store request handshake
//   mem_ren/wen/addr/wdata/alu           memory-port request (registered)
//   mem_rvalid/wready/rdata              memory-port response
//   ld_resp_valid/data/tag               1-cycle load response
//   st_done                              1-cycle store completion
//   busy                                 arbiter not in IDLE
//
// Configuration macro: YSYX_LSU_ARB_STARVE_EN
// ----------------------------------------------------------------------------
module ysyx_exu_lsu_arb
    import ysyx_exu_lsu_arb_pkg::*;
#(
    parameter  int XLEN         = 32,
    parameter  int RS_SIZE      = 4,
    parameter  int STARVE_LIMIT = 4,
    localparam int TAG_W        = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_pipeline,

    input  logic             ld_req_valid,
    output logic             ld_req_ready,
    input  logic [XLEN-1:0]  ld_req_addr,
    input  logic [ALU_W-1:0] ld_req_alu,
    input  logic [TAG_W-1:0] ld_req_tag,

    input  logic             st_req_valid,
    output logic             st_req_ready,
    input  logic [XLEN-1:0]  st_req_addr,
    input  logic [XLEN-1:0]  st_req_data,
    input  logic [ALU_W-1:0] st_req_alu,

    output logic             mem_ren,
    output logic             mem_wen,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [ALU_W-1:0] mem_alu,

    input  logic             mem_rvalid,
    input  logic             mem_wready,
    input  logic [XLEN-1:0]  mem_rdata,

    output logic             ld_resp_valid,
    output logic [XLEN-1:0]  ld_resp_data,
    output logic [TAG_W-1:0] ld_resp_tag,
    output logic             st_done,
    output logic             busy
);

    lsu_arb_state_e   r_state;
    logic             r_mem_ren;
    logic             r_mem_wen;
    logic [XLEN-1:0]  r_mem_addr;
    logic [XLEN-1:0]  r_mem_wdata;
    logic [ALU_W-1:0] r_mem_alu;
    logic             r_ld_resp_valid;
    logic [XLEN-1:0]  r_ld_resp_data;
    logic [TAG_W-1:0] r_ld_tag;
    logic             r_st_done;
    logic             r_busy;

    logic w_idle;
    logic w_ld_elig;
    logic w_starve_hit;
    logic w_st_ready;
    logic w_ld_ready;

    // Handshakes only happen in IDLE; a flush in IDLE makes the load
    // ineligible for that cycle, so it cannot steal the grant either.
    assign w_idle     = (r_state == IDLE) && !reset;
    assign w_ld_elig  = ld_req_valid && !flush_pipeline;
    assign w_st_ready = w_idle && st_req_valid && !(w_ld_elig && w_starve_hit);
    assign w_ld_ready = w_idle && w_ld_elig && !w_st_ready;

`ifdef YSYX_LSU_ARB_STARVE_EN
    ysyx_exu_lsu_arb_starve #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clock      (clock),
        .reset      (reset),
        .i_idle     (w_idle),
        .i_ld_valid (ld_req_valid),
        .i_st_grant (w_st_ready),
        .i_ld_grant (w_ld_ready),
        .o_hit      (w_starve_hit)
    );
`else
    // Strict store priority: the starvation limit has no meaning here.
    logic w_unused_starve_limit;
    assign w_unused_starve_limit = (STARVE_LIMIT != 0);
    assign w_starve_hit          = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            // Memory side is reset alongside, so in-flight accesses are
            // abandoned rather than drained.
            r_state         <= IDLE;
            r_mem_ren       <= 1'b0;
            r_mem_wen       <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_mem_alu       <= '0;
            r_ld_resp_valid <= 1'b0;
            r_ld_resp_data  <= '0;
            r_ld_tag        <= '0;
            r_st_done       <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_ld_resp_valid <= 1'b0;
            r_st_done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_st_ready) begin
                        r_mem_addr  <= st_req_addr;
                        r_mem_wdata <= st_req_data;
                        r_mem_alu   <= st_req_alu;
                        r_mem_wen   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= STORE;
                    end else if (w_ld_ready) begin
                        r_mem_addr  <= ld_req_addr;
                        r_mem_alu   <= ld_req_alu;
                        r_ld_tag    <= ld_req_tag;
                        r_mem_ren   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (mem_rvalid) begin
                        r_mem_ren <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                        // A flush coinciding with the response kills it.
                        if (!flush_pipeline) begin
                            r_ld_resp_valid <= 1'b1;
                            r_ld_resp_data  <= mem_rdata;
                        end
                    end else if (flush_pipeline) begin
                        // Memory already has the read; keep mem_ren up
                        // until it answers, then throw the data away.
                        r_state <= DRAIN;
                    end
                end
                STORE: begin
                    if (mem_wready) begin
                        r_mem_wen <= 1'b0;
                        r_st_done <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                DRAIN: begin
                    if (mem_rvalid) begin
                        r_mem_ren <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_mem_ren <= 1'b0;
                    r_mem_wen <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign ld_req_ready  = w_ld_ready;
    assign st_req_ready  = w_st_ready;
    assign mem_ren       = r_mem_ren;
    assign mem_wen       = r_mem_wen;
    assign mem_addr      = r_mem_addr;
    assign mem_wdata     = r_mem_wdata;
    assign mem_alu       = r_mem_alu;
    assign ld_resp_valid = r_ld_resp_valid;
    assign ld_resp_data  = r_ld_resp_data;
    assign ld_resp_tag   = r_ld_tag;
    assign st_done       = r_st_done;
    assign busy          = r_busy;

endmodule

// File: tb/tb_ysyx_exu_lsu_arb.sv
// ----------------------------------------------------------------------------
// tb_ysyx_exu_lsu_arb
// Directed bench for the load/store arbiter. Inputs change 1 ns after the
// rising edge; outputs are sampled at that same point (well away from the
// edge). The starvation scenario adapts its expected grant point to whether
// YSYX_LSU_ARB_STARVE_EN is defined.
// ----------------------------------------------------------------------------
module tb_ysyx_exu_lsu_arb;

    localparam int XLEN  = 32;
    localparam int TAG_W = 2;

`ifdef YSYX_LSU_ARB_STARVE_EN
    localparam int LD_AFTER = 4;
`else
    localparam int LD_AFTER = 6;
`endif

    logic             clock;
    logic             reset;
    logic             flush_pipeline;
    logic             ld_req_valid;
    logic             ld_req_ready;
    logic [XLEN-1:0]  ld_req_addr;
    logic [4:0]       ld_req_alu;
    logic [TAG_W-1:0] ld_req_tag;
    logic             st_req_valid;
    logic             st_req_ready;
    logic [XLEN-1:0]  st_req_addr;
    logic [XLEN-1:0]  st_req_data;
    logic [4:0]       st_req_alu;
    logic             mem_ren;
    logic             mem_wen;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic [4:0]       mem_alu;
    logic             mem_rvalid;
    logic             mem_wready;
    logic [XLEN-1:0]  mem_rdata;
    logic             ld_resp_valid;
    logic [XLEN-1:0]  ld_resp_data;
    logic [TAG_W-1:0] ld_resp_tag;
    logic             st_done;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_exu_lsu_arb #(
        .XLEN         (XLEN),
        .RS_SIZE      (4),
        .STARVE_LIMIT (4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .flush_pipeline (flush_pipeline),
        .ld_req_valid   (ld_req_valid),
        .ld_req_ready   (ld_req_ready),
        .ld_req_addr    (ld_req_addr),
        .ld_req_alu     (ld_req_alu),
        .ld_req_tag     (ld_req_tag),
        .st_req_valid   (st_req_valid),
        .st_req_ready   (st_req_ready),
        .st_req_addr    (st_req_addr),
        .st_req_data    (st_req_data),
        .st_req_alu     (st_req_alu),
        .mem_ren        (mem_ren),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_alu        (mem_alu),
        .mem_rvalid     (mem_rvalid),
        .mem_wready     (mem_wready),
        .mem_rdata      (mem_rdata),
        .ld_resp_valid  (ld_resp_valid),
        .ld_resp_data   (ld_resp_data),
        .ld_resp_tag    (ld_resp_tag),
        .st_done        (st_done),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush_pipeline = 1'b0;
        ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_alu = '0; ld_req_tag = '0;
        st_req_valid = 1'b0; st_req_addr = '0; st_req_data = '0; st_req_alu = '0;
        mem_rvalid = 1'b0; mem_wready = 1'b0; mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_ren",   32'(mem_ren), 32'd0);
        check("rst_wen",   32'(mem_wen), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_rv",    32'(ld_resp_valid), 32'd0);
        check("rst_tag",   32'(ld_resp_tag), 32'd0);

        // Single load, response 3 cycles after mem_ren
        ld_req_valid = 1'b1; ld_req_addr = 32'h8000_0010; ld_req_tag = 2'd2; ld_req_alu = 5'h04;
        #1;
        check("ld_ready", 32'(ld_req_ready), 32'd1);
        check("ld_st_rdy", 32'(st_req_ready), 32'd0);
        tick();
        ld_req_valid = 1'b0;
        check("ld_ren",  32'(mem_ren), 32'd1);
        check("ld_wen",  32'(mem_wen), 32'd0);
        check("ld_addr", mem_addr, 32'h8000_0010);
        check("ld_alu",  32'(mem_alu), 32'h04);
        check("ld_busy", 32'(busy), 32'd1);
        tick();
        check("ld_hold_addr", mem_addr, 32'h8000_0010);
        check("ld_no_rdy", 32'(ld_req_ready), 32'd0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rvalid = 1'b0; mem_rdata = '0;
        check("ld_rv",    32'(ld_resp_valid), 32'd1);
        check("ld_rdata", ld_resp_data, 32'hDEAD_BEEF);
        check("ld_rtag",  32'(ld_resp_tag), 32'd2);
        check("ld_ren0",  32'(mem_ren), 32'd0);
        check("ld_idle",  32'(busy), 32'd0);
        tick();
        check("ld_rv_pulse", 32'(ld_resp_valid), 32'd0);

        // Store and load together: store first, then load
        st_req_valid = 1'b1; st_req_addr = 32'h8000_0020; st_req_data = 32'h1234_5678; st_req_alu = 5'h02;
        ld_req_valid = 1'b1; ld_req_addr = 32'h8000_0040; ld_req_tag = 2'd1; ld_req_alu = 5'h05;
        #1;
        check("pri_st_rdy", 32'(st_req_ready), 32'd1);
        check("pri_ld_rdy", 32'(ld_req_ready), 32'd0);
        tick();
        st_req_valid = 1'b0;
        check("pri_wen",   32'(mem_wen), 32'd1);
        check("pri_ren",   32'(mem_ren), 32'd0);
        check("pri_addr",  mem_addr, 32'h8000_0020);
        check("pri_wdata", mem_wdata, 32'h1234_5678);
        check("pri_alu",   32'(mem_alu), 32'h02);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        check("pri_done",   32'(st_done), 32'd1);
        check("pri_wen0",   32'(mem_wen), 32'd0);
        check("pri_ld_rdy2", 32'(ld_req_ready), 32'd1);
        tick();
        ld_req_valid = 1'b0;
        check("pri_done_pulse", 32'(st_done), 32'd0);
        check("pri_ld_ren",  32'(mem_ren), 32'd1);
        check("pri_ld_addr", mem_addr, 32'h8000_0040);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055;
        tick();
        mem_rvalid = 1'b0;
        check("pri_ld_rv",  32'(ld_resp_valid), 32'd1);
        check("pri_ld_tag", 32'(ld_resp_tag), 32'd1);
        tick();

        // Six stores queued while a load is held valid
        begin
            int stores = 0;
            bit ld_served = 1'b0;
            ld_req_valid = 1'b1; ld_req_addr = 32'h8000_0100; ld_req_tag = 2'd3;
            st_req_valid = 1'b1;
            for (int g = 0; g < 7; g++) begin
                st_req_addr = 32'h8000_0200 + 32'(stores * 4);
                st_req_data = 32'hA000_0000 + 32'(stores);
                #1;
                if (!ld_served && stores == LD_AFTER) begin
                    check("stv_ld_rdy", 32'(ld_req_ready), 32'd1);
                    check("stv_st_rdy", 32'(st_req_ready), 32'd0);
                    tick();
                    ld_req_valid = 1'b0;
                    check("stv_ren", 32'(mem_ren), 32'd1);
                    mem_rvalid = 1'b1; mem_rdata = 32'h0000_0777;
                    tick();
                    mem_rvalid = 1'b0;
                    check("stv_rv", 32'(ld_resp_valid), 32'd1);
                    ld_served = 1'b1;
                end else begin
                    check("stv_st_rdy", 32'(st_req_ready), 32'd1);
                    check("stv_ld_rdy", 32'(ld_req_ready), 32'd0);
                    tick();
                    check("stv_wdata", mem_wdata, 32'hA000_0000 + 32'(stores));
                    mem_wready = 1'b1;
                    tick();
                    mem_wready = 1'b0;
                    check("stv_done", 32'(st_done), 32'd1);
                    stores++;
                    if (stores == 6) st_req_valid = 1'b0;
                end
            end
            check("stv_served", 32'(ld_served), 32'd1);
            tick();
        end

        // Flush in IDLE blocks the load
        ld_req_valid = 1'b1; ld_req_addr = 32'h8000_0030; ld_req_tag = 2'd0; flush_pipeline = 1'b1;
        #1;
        check("fl_idle_rdy", 32'(ld_req_ready), 32'd0);
        tick();
        check("fl_idle_ren", 32'(mem_ren), 32'd0);
        flush_pipeline = 1'b0;
        tick();
        ld_req_valid = 1'b0;
        check("fl_grant_ren", 32'(mem_ren), 32'd1);
        // Flush one cycle after grant -> DRAIN
        flush_pipeline = 1'b1;
        tick();
        flush_pipeline = 1'b0;
        ld_req_valid = 1'b1; ld_req_addr = 32'h8000_0050; ld_req_tag = 2'd3;
        st_req_valid = 1'b1; st_req_addr = 32'h8000_0060;
        #1;
        check("dr_ren",    32'(mem_ren), 32'd1);
        check("dr_busy",   32'(busy), 32'd1);
        check("dr_ld_rdy", 32'(ld_req_ready), 32'd0);
        check("dr_st_rdy", 32'(st_req_ready), 32'd0);
        st_req_valid = 1'b0;
        tick();
        check("dr_ren2", 32'(mem_ren), 32'd1);
        check("dr_rv0",  32'(ld_resp_valid), 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
        tick();
        mem_rvalid = 1'b0;
        check("dr_ren0", 32'(mem_ren), 32'd0);
        check("dr_norv", 32'(ld_resp_valid), 32'd0);
        check("dr_idle", 32'(busy), 32'd0);
        check("dr_next_rdy", 32'(ld_req_ready), 32'd1);
        tick();
        ld_req_valid = 1'b0;
        check("dr_next_addr", mem_addr, 32'h8000_0050);
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_600D;
        tick();
        mem_rvalid = 1'b0;
        check("dr_next_rv",   32'(ld_resp_valid), 32'd1);
        check("dr_next_data", ld_resp_data, 32'h0000_600D);
        check("dr_next_tag",  32'(ld_resp_tag), 32'd3);
        tick();

        // Flush in the same cycle as mem_rvalid
        ld_req_valid = 1'b1; ld_req_addr = 32'h8000_0070; ld_req_tag = 2'd1;
        tick();
        ld_req_valid = 1'b0;
        flush_pipeline = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0FEE;
        tick();
        flush_pipeline = 1'b0; mem_rvalid = 1'b0;
        check("flrv_norv", 32'(ld_resp_valid), 32'd0);
        check("flrv_ren0", 32'(mem_ren), 32'd0);
        check("flrv_idle", 32'(busy), 32'd0);
        tick();

        // Flush during STORE has no effect
        st_req_valid = 1'b1; st_req_addr = 32'h8000_0080; st_req_data = 32'hCAFE_F00D;
        tick();
        st_req_valid = 1'b0;
        flush_pipeline = 1'b1;
        tick();
        check("fls_wen",   32'(mem_wen), 32'd1);
        check("fls_busy",  32'(busy), 32'd1);
        tick();
        flush_pipeline = 1'b0;
        check("fls_wen2",  32'(mem_wen), 32'd1);
        check("fls_wdata", mem_wdata, 32'hCAFE_F00D);
        mem_wready = 1'b1;
        tick();
        mem_wready = 1'b0;
        check("fls_done", 32'(st_done), 32'd1);
        check("fls_wen0", 32'(mem_wen), 32'd0);
        tick();

        // Reset in the middle of a load
        ld_req_valid = 1'b1; ld_req_addr = 32'h8000_0090; ld_req_tag = 2'd2;
        tick();
        ld_req_valid = 1'b0;
        check("rl_ren", 32'(mem_ren), 32'd1);
        reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        reset = 1'b0; mem_rvalid = 1'b0;
        check("rl_ren0",  32'(mem_ren), 32'd0);
        check("rl_wen0",  32'(mem_wen), 32'd0);
        check("rl_busy",  32'(busy), 32'd0);
        check("rl_rv",    32'(ld_resp_valid), 32'd0);
        check("rl_addr",  mem_addr, 32'd0);
        check("rl_wdata", mem_wdata, 32'd0);
        check("rl_alu",   32'(mem_alu), 32'd0);
        check("rl_rdata", ld_resp_data, 32'd0);
        check("rl_tag",   32'(ld_resp_tag), 32'd0);
        check("rl_done",  32'(st_done), 32'd0);
        tick();
        check("rl_rv2", 32'(ld_resp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_exu_lsu_arb.md
YSYX_EXU_LSU_ARB -- requirements
Module: ysyx_exu_lsu_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter RS_SIZE, default 4, reservation-station entries; tag width is clog2(RS_SIZE).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive store grants tolerated while a load waits.
REQ-004 SHALL have port clock, input, 1, the only clock.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port flush_pipeline, input, 1, discards speculative loads.
REQ-007 SHALL have ports ld_req_valid/ld_req_ready (in/out, 1), ld_req_addr (in, XLEN), ld_req_alu (in, 5) and ld_req_tag (in, tag width): load request.
REQ-008 SHALL have ports st_req_valid/st_req_ready (in/out, 1), st_req_addr and st_req_data (in, XLEN) and st_req_alu (in, 5): committed-store request.
REQ-009 SHALL have ports mem_ren and mem_wen (out, 1), mem_addr and mem_wdata (out, XLEN) and mem_alu (out, 5): memory-port request.
REQ-010 SHALL have ports mem_rvalid and mem_wready (in, 1) and mem_rdata (in, XLEN): memory-port response.
REQ-011 SHALL have ports ld_resp_valid (out, 1), ld_resp_data (out, XLEN), ld_resp_tag (out, tag width), st_done (out, 1) and busy (out, 1).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, STORE, DRAIN.
REQ-013 SHALL assert ld_req_ready and st_req_ready only in IDLE; only one of them is asserted in any cycle, and only when the matching valid is high.
REQ-014 SHALL, in IDLE with both valids high, grant the store, unless the starvation count has reached STARVE_LIMIT, in which case it grants the load.
REQ-015 SHALL register the granted request's address, data, alu and tag on the handshake cycle N, and drive mem_ren or mem_wen from cycle N+1 until the response.
REQ-016 SHALL hold mem_addr, mem_wdata and mem_alu stable while mem_ren or mem_wen is high; mem_ren and mem_wen are never high together.
REQ-017 SHALL leave LOAD on mem_rvalid: it drops mem_ren, pulses ld_resp_valid for exactly 1 cycle with the captured mem_rdata and tag, and returns to IDLE.
REQ-018 SHALL leave STORE on mem_wready: it drops mem_wen, pulses st_done for 1 cycle and returns to IDLE.
REQ-019 SHALL give a new request a 1-cycle IDLE gap; back-to-back accesses therefore cost response latency + 2 cycles.
REQ-020 SHALL handle flush_pipeline as follows:
  - in IDLE: no load is accepted that cycle;
  - in LOAD before mem_rvalid: go to DRAIN, keep mem_ren high until mem_rvalid, drop the data, suppress ld_resp_valid, then go to IDLE;
  - in LOAD in the same cycle as mem_rvalid: drop the response and go to IDLE;
  - in STORE: no effect, because the store is committed and completes normally.
REQ-021 SHALL block ld_req_ready in DRAIN; st_req_ready is also low in DRAIN.
REQ-022 SHALL assert busy in every state except IDLE.
REQ-023 SHALL pass st_req_alu and ld_req_alu through unmodified as mem_alu, with no width or sign handling in this block.

Reset
REQ-024 SHALL, on reset, enter IDLE and clear the starvation counter.
REQ-025 SHALL, on reset, drive all outputs to 0: mem_ren, mem_wen, ld_resp_valid, st_done, busy, mem_addr, mem_wdata, mem_alu, ld_resp_data and ld_resp_tag.
REQ-026 SHALL let reset override flush and any in-flight access, with no drain; the memory side is reset together with this block.

Configuration
REQ-027 SHALL, with YSYX_LSU_ARB_STARVE_EN defined, run the starvation counter as follows:
  - increment on each store grant while ld_req_valid is high;
  - saturate at STARVE_LIMIT;
  - clear on any load grant or whenever ld_req_valid is low in IDLE.
REQ-028 SHALL, without YSYX_LSU_ARB_STARVE_EN, use strict store priority, have no counter register and ignore STARVE_LIMIT.

Structure
REQ-029 SHALL place the FSM state enum (2 bits) and the alu-op width constant (5) in the shared ysyx package; the tag width is derived locally.
REQ-030 SHALL keep the starvation counter in one sub-module, ysyx_exu_lsu_arb_starve, instantiated only under YSYX_LSU_ARB_STARVE_EN.

Verification
REQ-031 SHALL cover this case: a load to 0x8000_0010 with tag 2 and mem_rvalid 3 cycles after mem_ren -> ld_resp_valid pulses once with mem_rdata 0xDEAD_BEEF and tag 2, then the FSM is in IDLE.
REQ-032 SHALL cover this case: a store and a load valid together in IDLE -> the store to 0x8000_0020 with data 0x1234_5678 is granted first, st_done pulses, and the load is granted next.
REQ-033 SHALL cover this case, with STARVE_EN and STARVE_LIMIT=4: 6 stores queued while a load is held valid -> the load is granted after the 4th store.
REQ-034 SHALL cover this case: flush 1 cycle after a load grant -> DRAIN holds mem_ren until mem_rvalid, no ld_resp_valid is produced, and the next request is accepted after the FSM returns to IDLE.
REQ-035 SHALL cover this case: flush during STORE -> mem_wen stays high, st_done still pulses, and the store is not lost.
REQ-036 SHALL cover this case: reset asserted mid-LOAD -> next cycle the FSM is in IDLE with all outputs 0 and no ld_resp_valid.
